// File: rtl/adc_req_scheduler.sv
// Round-robin scheduler sharing one SPI ADC controller among NUM_REQ requesters.
// Each accepted request becomes one config word, one start pulse and one tagged response.
module adc_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter bit UNIPOLAR    = 1'b1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_data,
  output logic                 rsp_err,
  output logic [5:0]           adc_conf,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [11:0]          adc_data
);
  // Handshake: a request or response transfers on the rising edge where valid and ready
  // are both 1; valid is held by the source until then, ready may depend on valid.
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [11:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [5:0]       conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  cand;
  logic [2:0]       win_ch;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_ch    = req_ch[3*cand +: 3];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_found && !reset) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    conf_d   = conf_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d     = win_idx;
          rr_ptr_d = win_idx;
          conf_d   = {1'b1, win_ch[0], win_ch[2], win_ch[1], UNIPOLAR, 1'b0};
          start_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving on the last timeout cycle still counts as a good sample.
        if (adc_done) begin
          data_d  = adc_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PTR_RST;
      id_q     <= '0;
      conf_q   <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      conf_q   <= conf_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign adc_conf  = conf_q;
  assign adc_start = start_q;

endmodule

// File: tb/tb_adc_req_scheduler.sv
// Bench for adc_req_scheduler: scenario tasks drive requests and a simple ADC model,
// a negedge scoreboard checks every accepted response against the expected queue.
module tb_adc_req_scheduler;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_ch;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [11:0]          rsp_data;
  logic                 rsp_err;
  logic [5:0]           adc_conf;
  logic                 adc_start;
  logic                 adc_done;
  logic [11:0]          adc_data;

  int vec_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  logic [14:0] exp_q[$];  // {id, err, data}
  logic [14:0] mon_exp;

  adc_req_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .UNIPOLAR(1'b1), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .adc_conf(adc_conf), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", err_cnt);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (adc_start === 1'b1) start_cnt++;
  end

  // scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL rsp_unexpected: got id=%0d err=%0b data=%h, none expected",
                 rsp_id, rsp_err, rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_id, rsp_err, rsp_data} !== mon_exp) begin
          err_cnt++;
          $display("FAIL rsp_check: got id=%0d err=%0b data=%h, expected id=%0d err=%0b data=%h",
                   rsp_id, rsp_err, rsp_data, mon_exp[14:13], mon_exp[12], mon_exp[11:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic request(input int id, input logic [2:0] ch, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_ch[3*id +: 3] = ch;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // ADC model: waits for adc_start, optionally glitches done during ISSUE,
  // then returns data 'delay' cycles after the start cycle.
  task automatic adc_serve(input int delay, input logic [11:0] data, input bit spur,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (adc_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (spur) begin
        adc_done = 1'b1;
        adc_data = 12'hBEE;
      end
      @(posedge clk); #1;
      adc_done = 1'b0;
      repeat (delay - 1) @(posedge clk);
      #1;
      adc_done = 1'b1;
      adc_data = data;
      @(posedge clk); #1;
      adc_done = 1'b0;
      adc_data = '0;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_conf, adc_start} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b id=%0d data=%h err=%b conf=%b start=%b, all zero required",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_conf, adc_start);
    end
    req_valid = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_conversion();
    bit ok_req, ok_adc, ok_drn;
    int s0;
    rsp_ready = 1'b1;
    s0 = start_cnt;
    exp_q.push_back({2'd2, 1'b0, 12'hA5C});
    fork
      begin
        request(2, 3'd5, ok_req);
        @(negedge clk);
        vec_cnt++;
        if (adc_conf !== 6'b111010 || adc_start !== 1'b1) begin
          err_cnt++;
          $display("FAIL single_conf: conf=%b start=%b, expected conf=111010 start=1",
                   adc_conf, adc_start);
        end
      end
      begin
        adc_serve(10, 12'hA5C, 1'b0, ok_adc);
        @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 12'hA5C) begin
          err_cnt++;
          $display("FAIL single_latency: rsp_valid=%b data=%h one cycle after done, expected 1/a5c",
                   rsp_valid, rsp_data);
        end
      end
    join
    wait_drain(40, ok_drn);
    vec_cnt++;
    if (!(ok_req && ok_adc && ok_drn)) begin
      err_cnt++;
      $display("FAIL single_flow: grant=%0b start=%0b drained=%0b, expected all 1",
               ok_req, ok_adc, ok_drn);
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (start_cnt - s0 != 1) begin
      err_cnt++;
      $display("FAIL single_starts: %0d start pulses, expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit seen;
    rsp_ready = 1'b1;
    request(3, 3'd1, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL rst_grant: requester 3 not granted, expected grant");
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_conf, adc_start} !== '0) begin
      err_cnt++;
      $display("FAIL rst_async: req_ready=%b rsp_valid=%b id=%0d data=%h err=%b conf=%b start=%b, all zero required",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, adc_conf, adc_start);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    vec_cnt++;
    if (req_ready !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rst_ready_held: req_ready=%b during reset, expected 0000", req_ready);
    end
    reset = 1'b0;
    req_valid = 4'b0001;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL rst_ready_single: req_ready=%b, expected 0001", req_ready);
    end
    req_valid = 4'b1111;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL rst_rr_ptr: req_ready=%b with all requesting, expected 0001", req_ready);
    end
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    vec_cnt++;
    if (seen) begin
      err_cnt++;
      $display("FAIL rst_abort: rsp_valid seen after reset, expected no response");
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g;
    logic [11:0] d;
    logic [3:0] exp_rdy;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % NUM_REQ;
      exp_rdy = 4'b0001 << g;
      d = 12'h100 + 12'(k);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (req_ready !== 4'b0000) begin
          ok = 1'b1;
          break;
        end
      end
      vec_cnt++;
      if (!ok || req_ready !== exp_rdy) begin
        err_cnt++;
        $display("FAIL rr_grant_%0d: req_ready=%b, expected %b", k, req_ready, exp_rdy);
      end
      exp_q.push_back({ID_W'(g), 1'b0, d});
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      adc_serve(3, d, 1'b0, ok);
      vec_cnt++;
      if (!ok) begin
        err_cnt++;
        $display("FAIL rr_start_%0d: no adc_start, expected one", k);
      end
      req_valid[g] = 1'b1;
    end
    req_valid = '0;
    wait_drain(40, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL rr_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok, ok_adc;
    int n;
    rsp_ready = 1'b1;
    exp_q.push_back({2'd1, 1'b1, 12'h000});
    request(1, 3'd3, ok);
    @(negedge clk);
    vec_cnt++;
    if (!ok || adc_start !== 1'b1 || adc_conf !== 6'b110110) begin
      err_cnt++;
      $display("FAIL to_issue: grant=%0b start=%b conf=%b, expected 1/1/110110", ok, adc_start, adc_conf);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) break;
    end
    // TIMEOUT_CYC cycles in WAIT, then the first RESP cycle
    vec_cnt++;
    if (n != TIMEOUT_CYC + 1 || rsp_err !== 1'b1 || rsp_data !== 12'h000) begin
      err_cnt++;
      $display("FAIL to_latency: rsp after %0d cycles err=%b data=%h, expected %0d cycles err=1 data=000",
               n, rsp_err, rsp_data, TIMEOUT_CYC + 1);
    end
    exp_q.push_back({2'd3, 1'b0, 12'h7FF});
    fork
      begin
        request(3, 3'd7, ok);
        @(negedge clk);
        vec_cnt++;
        if (!ok || adc_conf !== 6'b111110) begin
          err_cnt++;
          $display("FAIL to_next_conf: grant=%0b conf=%b, expected 1/111110", ok, adc_conf);
        end
      end
      adc_serve(5, 12'h7FF, 1'b0, ok_adc);
    join
    wait_drain(40, ok);
    vec_cnt++;
    if (!ok || !ok_adc) begin
      err_cnt++;
      $display("FAIL to_next_flow: start=%0b drained=%0b, expected 1/1", ok_adc, ok);
    end
  endtask

  task automatic test_backpressure();
    bit ok_req, ok_adc, ok;
    rsp_ready = 1'b0;
    exp_q.push_back({2'd3, 1'b0, 12'h3C3});
    fork
      request(3, 3'd2, ok_req);
      adc_serve(4, 12'h3C3, 1'b0, ok_adc);
    join
    req_ch[3*1 +: 3] = 3'd6;
    req_valid = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 12'h3C3 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000 || adc_start !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: valid=%b id=%0d data=%h err=%b ready=%b start=%b, expected 1/3/3c3/0/0000/0",
                 i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, adc_start);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL bp_next_grant: req_ready=%b, expected 0010", req_ready);
    end
    exp_q.push_back({2'd1, 1'b0, 12'h111});
    fork
      begin
        @(posedge clk); #1;
        req_valid = '0;
      end
      adc_serve(2, 12'h111, 1'b0, ok);
    join
    ok_adc = ok_adc && ok;
    wait_drain(40, ok);
    vec_cnt++;
    if (!(ok_req && ok_adc && ok)) begin
      err_cnt++;
      $display("FAIL bp_flow: grant=%0b start=%0b drained=%0b, expected all 1", ok_req, ok_adc, ok);
    end
  endtask

  task automatic test_spurious_done();
    bit ok_req, ok_adc, ok;
    int s0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    adc_done = 1'b1;
    adc_data = 12'hBAD;
    @(posedge clk); #1;
    adc_done = 1'b0;
    adc_data = '0;
    @(negedge clk);
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL spur_idle: rsp_valid=%b after idle done, expected 0", rsp_valid);
    end
    s0 = start_cnt;
    exp_q.push_back({2'd0, 1'b0, 12'h5A5});
    fork
      request(0, 3'd4, ok_req);
      adc_serve(6, 12'h5A5, 1'b1, ok_adc);
    join
    vec_cnt++;
    if (adc_conf !== 6'b101010) begin
      err_cnt++;
      $display("FAIL spur_conf: conf=%b, expected 101010", adc_conf);
    end
    wait_drain(40, ok);
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (!(ok_req && ok_adc && ok) || start_cnt - s0 != 1 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL spur_single: grant=%0b start=%0b drained=%0b starts=%0d valid=%b, expected 1/1/1/1/0",
               ok_req, ok_adc, ok, start_cnt - s0, rsp_valid);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_ch    = '0;
    rsp_ready = 1'b1;
    adc_done  = 1'b0;
    adc_data  = '0;
    test_reset();
    test_single_conversion();
    test_reset_mid_wait();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_spurious_done();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL final_queue: %0d responses never produced, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
